cprs_packer: RTL and testbench
==============================

CPRS_PACKER -- requirements
Module: cprs_packer

Interface
REQ-001 Parameter OW, default 16, sample width per I/Q component from the compression stage.
REQ-002 Parameter FIFO_DEPTH, default 32, input-beat entries buffered; power of two, at least 4.
REQ-003 clk  in  1  single clock; all logic on the rising edge.
REQ-004 rst_n  in  1  reset, asynchronous assertion, active-low.
REQ-005 i_sop, i_eop, i_vld  in  1 each  packet framing and beat valid from the compression stage; the input has no backpressure.
REQ-006 i_dout_re, i_dout_im  in  16 x OW each  compressed samples, channels 0..15.
REQ-007 i_shift  in  5  block exponent; i_slot_idx in 7, i_symb_idx in 4, i_prb_idx in 9, i_type in 4, i_info in 8; all are packet metadata.
REQ-008 o_vld  out  1  output beat valid; i_rdy  in  1  downstream ready.
REQ-009 o_data  out  16*OW (256)  output beat; o_sop, o_eop  out  1 each  output packet framing.
REQ-010 o_ovf  out  1  sticky overflow flag; o_drop_cnt  out  16  count of dropped input beats, saturating.

Function
REQ-011 Each i_vld beat shall push one FIFO entry: {sop, eop, re[15:0], im[15:0]}; metadata shall be pushed only with sop beats, into a separate header FIFO of the same depth.
REQ-012 Full shall be decoded from the registered occupancy count; a push while full shall drop the beat, set o_ovf, and increment o_drop_cnt, even if a pop occurs in the same cycle.
REQ-013 A dropped sop beat shall also drop its header. Subsequent non-sop beats still push normally, because the downstream is expected to detect the broken packet.
REQ-014 The output FSM states shall be IDLE, HDR, LO, HI.
- IDLE->HDR when the FIFO is non-empty and the head sop=1.
- IDLE->LO when the head sop=0.
- HDR->LO, LO->HI on a handshake.
- HI->IDLE on a handshake, popping the entry at that handshake.
REQ-015 HDR beat: o_data[36:0] = {info, type, prb_idx, symb_idx, slot_idx, shift}, with shift in [4:0]; upper bits 0; o_sop=1.
REQ-016 LO beat: channels 0..7, each channel {im[OW-1:0], re[OW-1:0]}, with channel k at bits [32k+31:32k].
REQ-017 HI beat: channels 8..15 in the same layout; o_eop=1 on the HI beat only when the entry eop=1.
REQ-018 o_sop, o_eop, o_vld and o_data shall be registered outputs. Once o_vld=1, they shall hold stable until o_vld&i_rdy.
REQ-019 Latency: the first i_vld beat into an empty FIFO shall give o_vld=1 exactly 2 cycles later, with i_rdy held at 1.
REQ-020 Throughput: a continuous i_rdy=1 output shall sustain one input beat per 2 cycles, plus one cycle per packet for the header.
REQ-021 A push and a pop in the same cycle shall leave occupancy unchanged; the pointers wrap modulo FIFO_DEPTH.
REQ-022 o_drop_cnt shall saturate at 0xFFFF; o_ovf shall clear only on reset.
REQ-023 A sop beat arriving mid-packet shall be accepted as a new packet without error; framing is not checked beyond REQ-013.

Reset
REQ-024 While rst_n=0, all outputs shall be 0, the FSM shall be IDLE, and the pointers, occupancy, o_ovf and o_drop_cnt shall be 0.
REQ-025 Reset mid-packet shall discard all buffered entries. The first packet after reset shall start with a header only if a new sop arrives.
REQ-026 Deassertion of rst_n shall be synchronised internally. The first push shall be accepted on the second clock edge after rst_n rises.

Verification
REQ-027 Single packet test:
- Stimulus: 3 beats, sop on beat 0, eop on beat 2, shift=5, prb=9, i_rdy=1.
- Response: 7 output beats HDR, LO, HI, LO, HI, LO, HI.
- The header has [4:0]=5 and prb field=9; o_eop=1 on beat 7 only; the first o_vld comes 2 cycles after the first i_vld.
REQ-028 Backpressure test:
- Stimulus: i_rdy toggles 1/0 each cycle during a 4-beat packet.
- Response: no beat is lost or duplicated, and o_data is held stable while i_rdy=0.
REQ-029 Overflow test:
- Stimulus: i_rdy=0, then FIFO_DEPTH+3 consecutive i_vld beats.
- Response: o_ovf=1, o_drop_cnt=3, and exactly FIFO_DEPTH entries are emitted after i_rdy=1.
REQ-030 Full with simultaneous pop:
- Stimulus: FIFO full, and a push coincides with a pop.
- Response: the push is dropped, o_drop_cnt increments by 1, and occupancy becomes FIFO_DEPTH-1.
REQ-031 Mid-packet reset:
- Stimulus: rst_n pulses low during the HI beat of beat 1 of a 3-beat packet.
- Response: all outputs are 0 during reset.
- After reset, no output occurs until a new sop packet arrives, and that packet begins with a HDR beat.

Source files
------------

// File: rtl/cprs_packer.sv
// Packs compressed I/Q beats into header/low/high 16*OW-bit output beats.
// An input FIFO absorbs bursts; overflowing beats are dropped and counted.
module cprs_packer #(
  parameter int unsigned OW         = 16,
  parameter int unsigned FIFO_DEPTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_sop,
  input  logic             i_eop,
  input  logic             i_vld,
  input  logic [16*OW-1:0] i_dout_re,
  input  logic [16*OW-1:0] i_dout_im,
  input  logic [4:0]       i_shift,
  input  logic [6:0]       i_slot_idx,
  input  logic [3:0]       i_symb_idx,
  input  logic [8:0]       i_prb_idx,
  input  logic [3:0]       i_type,
  input  logic [7:0]       i_info,
  output logic             o_vld,
  input  logic             i_rdy,
  output logic [16*OW-1:0] o_data,
  output logic             o_sop,
  output logic             o_eop,
  output logic             o_ovf,
  output logic [15:0]      o_drop_cnt
);

  localparam int unsigned DW = 16 * OW;
  localparam int unsigned EW = 2 + 2 * DW;
  localparam int unsigned HW = 37;
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HDR  = 2'd1;
  localparam logic [1:0] S_LO   = 2'd2;
  localparam logic [1:0] S_HI   = 2'd3;

  // Reset asserts asynchronously, releases on the first clock edge after rst_n rises
  logic rst_sync_n;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync_n <= 1'b0;
    else        rst_sync_n <= 1'b1;
  end

  logic [EW-1:0] mem     [FIFO_DEPTH];
  logic [HW-1:0] hdr_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr, hdr_wr_ptr, hdr_rd_ptr;
  logic [CW-1:0] count;
  logic          full, push, drop, hdr_push, pop, hdr_pop;
  logic [HW-1:0] hdr_in, hdr_head;
  logic [EW-1:0] head_ent, next_ent;

  assign full     = (count == CW'(FIFO_DEPTH));
  assign push     = i_vld & ~full;
  assign drop     = i_vld & full;
  assign hdr_push = push & i_sop;
  assign hdr_in   = {i_info, i_type, i_prb_idx, i_symb_idx, i_slot_idx, i_shift};
  assign hdr_head = hdr_mem[hdr_rd_ptr];
  assign head_ent = mem[rd_ptr];
  assign next_ent = mem[rd_ptr + PW'(1)];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {i_sop, i_eop, i_dout_re, i_dout_im};
  end

  always_ff @(posedge clk) begin
    if (hdr_push) hdr_mem[hdr_wr_ptr] <= hdr_in;
  end

  // Pointers, occupancy and drop statistics
  always_ff @(posedge clk or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      hdr_wr_ptr <= '0;
      hdr_rd_ptr <= '0;
      count      <= '0;
      o_ovf      <= 1'b0;
      o_drop_cnt <= '0;
    end else begin
      if (push)     wr_ptr     <= wr_ptr + PW'(1);
      if (pop)      rd_ptr     <= rd_ptr + PW'(1);
      if (hdr_push) hdr_wr_ptr <= hdr_wr_ptr + PW'(1);
      if (hdr_pop)  hdr_rd_ptr <= hdr_rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
      if (drop) begin
        o_ovf <= 1'b1;
        if (o_drop_cnt != 16'hFFFF) o_drop_cnt <= o_drop_cnt + 16'd1;
      end
    end
  end

  // Eight channels of one entry as {im, re} pairs; upper selects channels 8..15
  function automatic logic [DW-1:0] half_beat(input logic [EW-1:0] ent, input logic upper);
    logic [DW-1:0] re;
    logic [DW-1:0] im;
    logic [DW-1:0] r;
    int            base;
    re   = ent[2*DW-1:DW];
    im   = ent[DW-1:0];
    r    = '0;
    base = upper ? 8 : 0;
    for (int k = 0; k < 8; k++) begin
      r[2*OW*k +: 2*OW] = {im[(base+k)*OW +: OW], re[(base+k)*OW +: OW]};
    end
    return r;
  endfunction

  logic [1:0]    state, state_nxt;
  logic          vld_nxt, sop_nxt, eop_nxt, hs, load;
  logic [DW-1:0] data_nxt;
  logic [EW-1:0] load_ent;

  always_ff @(posedge clk or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      state  <= S_IDLE;
      o_vld  <= 1'b0;
      o_data <= '0;
      o_sop  <= 1'b0;
      o_eop  <= 1'b0;
    end else begin
      state  <= state_nxt;
      o_vld  <= vld_nxt;
      o_data <= data_nxt;
      o_sop  <= sop_nxt;
      o_eop  <= eop_nxt;
    end
  end

  // On the HI handshake the next entry is loaded directly so no idle beat is inserted
  always_comb begin
    state_nxt = state;
    vld_nxt   = o_vld;
    data_nxt  = o_data;
    sop_nxt   = o_sop;
    eop_nxt   = o_eop;
    pop       = 1'b0;
    hdr_pop   = 1'b0;
    load      = 1'b0;
    load_ent  = head_ent;
    hs        = o_vld & i_rdy;

    case (state)
      S_IDLE: load = (count != '0);
      S_HDR: begin
        if (hs) begin
          state_nxt = S_LO;
          data_nxt  = half_beat(head_ent, 1'b0);
          sop_nxt   = 1'b0;
          eop_nxt   = 1'b0;
        end
      end
      S_LO: begin
        if (hs) begin
          state_nxt = S_HI;
          data_nxt  = half_beat(head_ent, 1'b1);
          eop_nxt   = head_ent[EW-2];
        end
      end
      S_HI: begin
        if (hs) begin
          pop = 1'b1;
          if (count > CW'(1)) begin
            load     = 1'b1;
            load_ent = next_ent;
          end else begin
            state_nxt = S_IDLE;
            vld_nxt   = 1'b0;
            data_nxt  = '0;
            sop_nxt   = 1'b0;
            eop_nxt   = 1'b0;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase

    if (load) begin
      vld_nxt = 1'b1;
      eop_nxt = 1'b0;
      if (load_ent[EW-1]) begin
        state_nxt = S_HDR;
        data_nxt  = DW'(hdr_head);
        sop_nxt   = 1'b1;
        hdr_pop   = 1'b1;
      end else begin
        state_nxt = S_LO;
        data_nxt  = half_beat(load_ent, 1'b0);
        sop_nxt   = 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cprs_packer.sv
// Bench for cprs_packer: expected output beats are built per accepted input beat
// in a queue; a negedge monitor compares every handshake and the drop statistics.
module tb_cprs_packer;

  localparam int unsigned OW    = 16;
  localparam int unsigned DEPTH = 32;
  localparam int unsigned DW    = 16 * OW;

  logic          clk, rst_n;
  logic          i_sop, i_eop, i_vld, i_rdy;
  logic [DW-1:0] i_dout_re, i_dout_im;
  logic [4:0]    i_shift;
  logic [6:0]    i_slot_idx;
  logic [3:0]    i_symb_idx;
  logic [8:0]    i_prb_idx;
  logic [3:0]    i_type;
  logic [7:0]    i_info;
  logic          o_vld, o_sop, o_eop, o_ovf;
  logic [DW-1:0] o_data;
  logic [15:0]   o_drop_cnt;

  cprs_packer #(.OW(OW), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_sop(i_sop), .i_eop(i_eop), .i_vld(i_vld),
    .i_dout_re(i_dout_re), .i_dout_im(i_dout_im),
    .i_shift(i_shift), .i_slot_idx(i_slot_idx), .i_symb_idx(i_symb_idx),
    .i_prb_idx(i_prb_idx), .i_type(i_type), .i_info(i_info),
    .o_vld(o_vld), .i_rdy(i_rdy), .o_data(o_data), .o_sop(o_sop), .o_eop(o_eop),
    .o_ovf(o_ovf), .o_drop_cnt(o_drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    logic          sop;
    logic          eop;
    logic          hi;
  } beat_t;

  beat_t         exp_q[$];
  beat_t         mb;
  int            m_occ, m_drop;
  logic          m_ovf, m_pop;
  int            n_tests, n_fail;
  int            hs_cnt, hi_cnt, eop_cnt, last_eop_hs;
  logic          prev_stall;
  logic [DW-1:0] prev_data;
  logic [2:0]    prev_ctl;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Expected output beats for one accepted input beat
  task automatic model_accept(input logic sop, input logic eop, input logic [DW-1:0] re,
                              input logic [DW-1:0] im, input logic [36:0] hdr);
    beat_t b;
    if (sop) begin
      b.data = DW'(hdr); b.sop = 1'b1; b.eop = 1'b0; b.hi = 1'b0;
      exp_q.push_back(b);
    end
    b.data = '0; b.sop = 1'b0; b.eop = 1'b0; b.hi = 1'b0;
    for (int k = 0; k < 8; k++) b.data[2*OW*k +: 2*OW] = {im[k*OW +: OW], re[k*OW +: OW]};
    exp_q.push_back(b);
    b.data = '0; b.eop = eop; b.hi = 1'b1;
    for (int k = 0; k < 8; k++)
      b.data[2*OW*k +: 2*OW] = {im[(k+8)*OW +: OW], re[(k+8)*OW +: OW]};
    exp_q.push_back(b);
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      m_occ = 0; m_drop = 0; m_ovf = 1'b0; prev_stall = 1'b0;
    end else begin
      chk("ovf", DW'(o_ovf), DW'(m_ovf));
      chk("drop_cnt", DW'(o_drop_cnt), DW'(m_drop));
      if (prev_stall) begin
        chk("hold_data", o_data, prev_data);
        chk("hold_ctl", DW'({o_vld, o_sop, o_eop}), DW'(prev_ctl));
      end
      m_pop = 1'b0;
      if (o_vld && i_rdy) begin
        if (exp_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL extra_beat: got beat %h expected none", o_data);
        end else begin
          mb = exp_q.pop_front();
          chk("beat_data", o_data, mb.data);
          chk("beat_ctl", DW'({o_sop, o_eop}), DW'({mb.sop, mb.eop}));
          hs_cnt++;
          if (mb.hi) begin m_pop = 1'b1; hi_cnt++; end
          if (o_eop) begin eop_cnt++; last_eop_hs = hs_cnt; end
        end
      end
      if (i_vld) begin
        if (m_occ == DEPTH) begin
          m_ovf = 1'b1;
          if (m_drop < 65535) m_drop++;
        end else begin
          m_occ++;
          model_accept(i_sop, i_eop, i_dout_re, i_dout_im,
                       {i_info, i_type, i_prb_idx, i_symb_idx, i_slot_idx, i_shift});
        end
      end
      if (m_pop) m_occ--;
      prev_stall = o_vld & ~i_rdy;
      prev_data  = o_data;
      prev_ctl   = {o_vld, o_sop, o_eop};
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    i_vld = 1'b0; i_sop = 1'b0; i_eop = 1'b0;
  endtask

  task automatic set_beat(input logic sop, input logic eop, input logic [4:0] sh,
                          input logic [8:0] prb);
    i_vld = 1'b1; i_sop = sop; i_eop = eop; i_shift = sh; i_prb_idx = prb;
    i_slot_idx = 7'($urandom); i_symb_idx = 4'($urandom);
    i_type = 4'($urandom); i_info = 8'($urandom);
    for (int k = 0; k < 16; k++) begin
      i_dout_re[k*OW +: OW] = OW'($urandom);
      i_dout_im[k*OW +: OW] = OW'($urandom);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_vld"},  DW'(o_vld), '0);
    chk({tag, "_data"}, o_data, '0);
    chk({tag, "_sop"},  DW'(o_sop), '0);
    chk({tag, "_eop"},  DW'(o_eop), '0);
    chk({tag, "_ovf"},  DW'(o_ovf), '0);
    chk({tag, "_drop"}, DW'(o_drop_cnt), '0);
  endtask

  task automatic do_reset();
    step();
    rst_n = 1'b0;
    idle();
    #1;
    chk_all_zero("rst");
    repeat (3) step();
    rst_n = 1'b1;
    repeat (3) step();
  endtask

  task automatic drain(input int maxc, input string nm);
    int c;
    c = 0;
    i_rdy = 1'b1;
    idle();
    while ((exp_q.size() != 0 || o_vld) && c < maxc) begin
      step();
      c++;
    end
    chk(nm, DW'(exp_q.size()), '0);
    chk({nm, "_vld"}, DW'(o_vld), '0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int hs0, e0, hi0, left;
  logic s, e;

  initial begin
    n_tests = 0; n_fail = 0; hs_cnt = 0; hi_cnt = 0; eop_cnt = 0; last_eop_hs = 0;
    rst_n = 1'b0; i_rdy = 1'b0; idle();
    i_dout_re = '0; i_dout_im = '0; i_shift = '0; i_slot_idx = '0; i_symb_idx = '0;
    i_prb_idx = '0; i_type = '0; i_info = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("init");

    // Single packet: first beat sampled on the second edge after reset release
    rst_n = 1'b1;
    step();
    hs0 = hs_cnt; e0 = eop_cnt;
    i_rdy = 1'b1;
    set_beat(1'b1, 1'b0, 5'd5, 9'd9);
    step();
    chk("lat_not_yet", DW'(o_vld), '0);
    set_beat(1'b0, 1'b0, 5'd0, 9'd0);
    step();
    chk("lat_vld", DW'(o_vld), DW'(1));
    chk("hdr_sop", DW'(o_sop), DW'(1));
    chk("hdr_shift", DW'(o_data[4:0]), DW'(5));
    chk("hdr_prb", DW'(o_data[24:16]), DW'(9));
    set_beat(1'b0, 1'b1, 5'd0, 9'd0);
    step();
    drain(100, "sp_drain");
    chk("sp_beats", DW'(hs_cnt - hs0), DW'(7));
    chk("sp_eops", DW'(eop_cnt - e0), DW'(1));
    chk("sp_eop_pos", DW'(last_eop_hs - hs0), DW'(7));

    // Backpressure: ready toggles every cycle
    hs0 = hs_cnt;
    for (int c = 0; c < 80; c++) begin
      step();
      if (c < 4) set_beat(c == 0, c == 3, 5'($urandom), 9'($urandom));
      else idle();
      i_rdy = c[0];
      if (c >= 4 && exp_q.size() == 0 && !o_vld) break;
    end
    chk("bp_left", DW'(exp_q.size()), '0);
    chk("bp_beats", DW'(hs_cnt - hs0), DW'(9));

    // Overflow: DEPTH+3 beats into a stalled output
    do_reset();
    i_rdy = 1'b0;
    for (int i = 0; i < DEPTH + 3; i++) begin
      step();
      set_beat(i == 0, i == DEPTH + 2, 5'($urandom), 9'($urandom));
    end
    step(); idle(); step();
    chk("ovf_flag", DW'(o_ovf), DW'(1));
    chk("ovf_drops", DW'(o_drop_cnt), DW'(3));
    hi0 = hi_cnt;
    drain(300, "ovf_drain");
    chk("ovf_entries", DW'(hi_cnt - hi0), DW'(DEPTH));

    // Full FIFO with a push coinciding with the HI pop
    do_reset();
    i_rdy = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      step();
      set_beat(1'b0, 1'b0, 5'd0, 9'd0);
    end
    step(); idle(); step();
    i_rdy = 1'b1;
    step();
    set_beat(1'b0, 1'b0, 5'd0, 9'd0);
    step();
    idle();
    chk("fp_drop", DW'(o_drop_cnt), DW'(1));
    chk("fp_ovf", DW'(o_ovf), DW'(1));
    hi0 = hi_cnt;
    drain(300, "fp_drain");
    chk("fp_remaining", DW'(hi_cnt - hi0), DW'(DEPTH - 1));

    // Randomized traffic, light then heavy backpressure
    do_reset();
    left = 0;
    for (int c = 0; c < 600; c++) begin
      step();
      i_rdy = (c < 300) ? ($urandom_range(99) < 80) : ($urandom_range(99) < 30);
      if ($urandom_range(99) < 60) begin
        if (left == 0 || $urandom_range(99) < 5) begin
          s = 1'b1;
          left = $urandom_range(5, 1);
        end else begin
          s = 1'b0;
        end
        left--;
        e = (left == 0);
        set_beat(s, e, 5'($urandom), 9'($urandom));
      end else begin
        idle();
      end
    end
    drain(3000, "rnd_drain");

    // Reset during the HI beat of beat 1 of a 3-beat packet
    i_rdy = 1'b1;
    hs0 = hs_cnt;
    step(); set_beat(1'b1, 1'b0, 5'($urandom), 9'($urandom));
    step(); set_beat(1'b0, 1'b0, 5'd0, 9'd0);
    step(); set_beat(1'b0, 1'b1, 5'd0, 9'd0);
    step(); idle();
    for (int c = 0; c < 40; c++) begin
      if (hs_cnt - hs0 >= 4) break;
      step();
    end
    chk("mr_reach_hi1", DW'(hs_cnt - hs0), DW'(4));
    chk("mr_pre_vld", DW'(o_vld), DW'(1));
    rst_n = 1'b0;
    #1;
    chk_all_zero("mr_rst");
    repeat (3) step();
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      step();
      chk("mr_quiet", DW'(o_vld), '0);
    end
    set_beat(1'b1, 1'b0, 5'($urandom), 9'($urandom));
    step(); set_beat(1'b0, 1'b1, 5'd0, 9'd0);
    step(); idle();
    for (int c = 0; c < 10; c++) begin
      if (o_vld) break;
      step();
    end
    chk("mr_first_vld", DW'(o_vld), DW'(1));
    chk("mr_first_sop", DW'(o_sop), DW'(1));
    drain(100, "mr_drain");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
